// File: rtl/sdram_axi_stream_rd.sv
// Streaming AXI4 read master: fetches a linear block of DW-bit words in
// 4 KB-safe bursts and presents them on a valid/ready stream through a
// local FIFO. A burst is only requested once FIFO space is reserved for
// every beat, so the R channel is never back-pressured.
module sdram_axi_stream_rd #(
    parameter int         DW         = 32,
    parameter int         BURST_LEN  = 16,
    parameter int         FIFO_DEPTH = 64,
    parameter logic [3:0] AXI_ID     = 4'd0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [31:0]   base_addr_i,
    input  logic [15:0]   words_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [31:0]   araddr_o,
    output logic [3:0]    arid_o,
    output logic [7:0]    arlen_o,
    output logic [1:0]    arburst_o,
    output logic          arvalid_o,
    input  logic          arready_i,
    input  logic [DW-1:0] rdata_i,
    input  logic          rvalid_i,
    input  logic          rlast_i,
    input  logic [3:0]    rid_i,
    input  logic [1:0]    rresp_i,
    output logic          rready_o,
    output logic [DW-1:0] data_o,
    output logic          valid_o,
    input  logic          ready_i
);

    localparam int BPW = DW / 8;
    localparam int LSB = $clog2(BPW);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;

    typedef enum logic [2:0] {IDLE, CALC, ADDR, DRAIN, DONE} state_t;

    state_t        state_q, state_n;
    logic [31:0]   addr_q;
    logic [15:0]   remaining_q;
    logic [8:0]    beats_q;
    logic [7:0]    len_q;
    logic [CW-1:0] reserved_q;
    logic [CW-1:0] count_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic          err_q;
    logic [DW-1:0] mem [FIFO_DEPTH];

    logic [12:0]   room_bytes;
    logic [12:0]   room_words;
    logic [16:0]   beats_min;
    logic [8:0]    beats_c;
    logic          space_ok;
    logic          start_ok;
    logic          ar_hs;
    logic          beat_ok;
    logic          push;
    logic          pop;
    logic          unused_r_sideband;

    // Beat ordering comes from the reservation count, not from RLAST/RID.
    assign unused_r_sideband = ^{rlast_i, rid_i};

    assign start_ok  = (state_q == IDLE) && start_i && (words_i != 16'd0);
    assign ar_hs     = (state_q == ADDR) && arready_i;
    assign busy_o    = (state_q != IDLE);
    assign rready_o  = busy_o;
    assign beat_ok   = rvalid_i && busy_o;
    assign push      = beat_ok && (count_q != CW'(FIFO_DEPTH));
    assign valid_o   = (count_q != '0);
    assign pop       = valid_o && ready_i;
    assign data_o    = valid_o ? mem[rd_ptr_q] : '0;
    assign err_o     = err_q;
    assign araddr_o  = addr_q;
    assign arlen_o   = len_q;
    assign arid_o    = AXI_ID;
    assign arburst_o = 2'b01;

    // Burst size: limited by BURST_LEN, the words left and the next 4 KB line; plus FIFO credit check.
    always_comb begin
        room_bytes = 13'd4096 - {1'b0, addr_q[11:0]};
        room_words = room_bytes >> LSB;
        beats_min  = 17'(BURST_LEN);
        if ({1'b0, remaining_q} < beats_min) beats_min = {1'b0, remaining_q};
        if ({4'b0, room_words} < beats_min) beats_min = {4'b0, room_words};
        beats_c  = beats_min[8:0];
        space_ok = (32'(count_q) + 32'(reserved_q) + 32'(beats_c)) <= 32'(FIFO_DEPTH);
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_n;
    end

    // FSM next state and AR/done outputs; a zero-length start passes through DRAIN so done lands at the usual offset.
    always_comb begin
        state_n   = state_q;
        arvalid_o = 1'b0;
        done_o    = 1'b0;
        case (state_q)
            IDLE:  if (start_i) state_n = (words_i != 16'd0) ? CALC : DRAIN;
            CALC:  if (space_ok) state_n = ADDR;
            ADDR: begin
                arvalid_o = 1'b1;
                if (arready_i) state_n = (remaining_q == 16'(beats_q)) ? DRAIN : CALC;
            end
            DRAIN: if (reserved_q == '0) state_n = DONE;
            DONE: begin
                done_o  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Request bookkeeping: address, words left and the burst held stable during ADDR.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q      <= '0;
            remaining_q <= '0;
            beats_q     <= '0;
            len_q       <= '0;
        end else begin
            if (start_ok) begin
                addr_q      <= base_addr_i & ~32'(BPW - 1);
                remaining_q <= words_i;
            end
            if ((state_q == CALC) && space_ok) begin
                beats_q <= beats_c;
                len_q   <= 8'(beats_c - 9'd1);
            end
            if (ar_hs) begin
                addr_q      <= addr_q + (32'(beats_q) << LSB);
                remaining_q <= remaining_q - 16'(beats_q);
            end
        end
    end

    // FIFO credit and occupancy: reservation grows per AR, shrinks per beat.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reserved_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            reserved_q <= reserved_q + (ar_hs ? CW'(beats_q) : '0)
                          - ((push && (reserved_q != '0)) ? CW'(1) : '0);
            count_q    <= count_q + CW'(push) - CW'(pop);
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    // Sticky error flag, cleared when a non-empty transfer starts.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                                err_q <= 1'b0;
        else if (start_ok)                        err_q <= 1'b0;
        else if (beat_ok && (rresp_i != 2'b00))   err_q <= 1'b1;
    end

    // FIFO storage; contents need no reset since data_o is masked while empty.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q] <= rdata_i;
    end

endmodule

// File: tb/tb_sdram_axi_stream_rd.sv
// Bench for sdram_axi_stream_rd: random-latency AXI read slave model,
// random output back-pressure, and a data scoreboard filled at start time.
module tb_sdram_axi_stream_rd;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [31:0] base_addr_i;
    logic [15:0] words_i;
    logic        busy_o, done_o, err_o;
    logic [31:0] araddr_o;
    logic [3:0]  arid_o;
    logic [7:0]  arlen_o;
    logic [1:0]  arburst_o;
    logic        arvalid_o, arready_i;
    logic [31:0] rdata_i;
    logic        rvalid_i, rlast_i;
    logic [3:0]  rid_i;
    logic [1:0]  rresp_i;
    logic        rready_o;
    logic [31:0] data_o;
    logic        valid_o, ready_i;

    int total = 0, bad = 0, out_cnt = 0, done_cnt = 0, beats_seen = 0, cyc = 0;
    int last_r_cyc = -1, err_hs_cyc = -1, err_beat = -1, ar_budget = -1;
    bit ready_hold = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] pend_q[$];
    logic [31:0] ar_addr_q[$];
    logic [7:0]  ar_len_q[$];
    int          ar_cyc_q[$];
    logic [31:0] mon_exp;

    sdram_axi_stream_rd dut (
        .clk_i(clk), .rst_i(rst), .start_i(start_i), .base_addr_i(base_addr_i),
        .words_i(words_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .araddr_o(araddr_o), .arid_o(arid_o), .arlen_o(arlen_o), .arburst_o(arburst_o),
        .arvalid_o(arvalid_o), .arready_i(arready_i), .rdata_i(rdata_i),
        .rvalid_i(rvalid_i), .rlast_i(rlast_i), .rid_i(rid_i), .rresp_i(rresp_i),
        .rready_o(rready_o), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] dataf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_1E0F;
    endfunction

    // AXI read slave: handshakes judged at negedge, new drive values after posedge.
    initial begin : axi_slave
        bit ah, rh;
        forever begin
            @(negedge clk);
            ah = arvalid_o && arready_i && !rst;
            rh = rvalid_i && rready_o && !rst;
            if (rst) pend_q.delete();
            if (rh) begin
                pend_q.delete(0);
                last_r_cyc = cyc;
                if (rresp_i != 2'b00) err_hs_cyc = cyc;
                beats_seen++;
            end
            if (ah) begin
                ar_addr_q.push_back(araddr_o);
                ar_len_q.push_back(arlen_o);
                ar_cyc_q.push_back(cyc);
                if (ar_budget > 0) ar_budget--;
                for (int k = 0; k <= int'(arlen_o); k++) pend_q.push_back(araddr_o + 32'(k * 4));
            end
            @(posedge clk); #1;
            arready_i = (ar_budget != 0) && ($urandom_range(0, 3) != 0);
            if (pend_q.size() != 0 && $urandom_range(0, 4) != 0) begin
                rvalid_i = 1'b1;
                rdata_i  = dataf(pend_q[0]);
                rresp_i  = (beats_seen == err_beat) ? 2'b10 : 2'b00;
                rlast_i  = (pend_q.size() == 1);
            end else begin
                rvalid_i = 1'b0;
                rresp_i  = 2'b00;
                rlast_i  = 1'b0;
            end
        end
    end

    // Output consumer: random ready unless held off.
    initial begin : ready_drv
        forever begin
            @(posedge clk); #1;
            ready_i = ready_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Stream scoreboard and done counter.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst && valid_o && ready_i) begin
                total++;
                out_cnt++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL stream_extra got=%h want=none", data_o);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (data_o !== mon_exp) begin
                        bad++;
                        $display("FAIL stream_data got=%h want=%h", data_o, mon_exp);
                    end
                end
            end
            if (!rst && done_o) done_cnt++;
        end
    end

    task automatic nstep();
        @(negedge clk); #1;
    endtask

    task automatic drive_start(input logic [31:0] base, input logic [15:0] n, input bit push_exp);
        logic [31:0] a;
        @(posedge clk); #1;
        start_i = 1'b1; base_addr_i = base; words_i = n;
        if (push_exp) begin
            a = base & 32'hFFFF_FFFC;
            for (int i = 0; i < int'(n); i++) exp_q.push_back(dataf(a + 32'(i * 4)));
        end
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        bit ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            nstep();
            if (done_o) begin ok = 1'b1; break; end
        end
        total++;
        if (!ok) begin bad++; $display("FAIL done_timeout got=0 want=1"); end
    endtask

    task automatic wait_empty(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (exp_q.size() == 0 && !valid_o) break;
            nstep();
        end
        total++;
        if (exp_q.size() != 0 || valid_o) begin
            bad++;
            $display("FAIL drain_timeout got=%0d want=0", exp_q.size());
        end
    endtask

    task automatic clear_log();
        ar_addr_q.delete(); ar_len_q.delete(); ar_cyc_q.delete();
    endtask

    task automatic test_reset();
        logic [31:0] got [11];
        logic [31:0] want [11];
        rst = 1'b1;
        repeat (3) nstep();
        for (int pass = 0; pass < 2; pass++) begin
            got  = '{32'(busy_o), 32'(done_o), 32'(err_o), 32'(arvalid_o), 32'(rready_o),
                     32'(valid_o), data_o, araddr_o, 32'(arlen_o), 32'(arburst_o), 32'(arid_o)};
            want = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
            for (int i = 0; i < 11; i++) begin
                total++;
                if (got[i] !== want[i]) begin
                    bad++;
                    $display("FAIL reset_out%0d pass%0d got=%h want=%h", i, pass, got[i], want[i]);
                end
            end
            @(posedge clk); #1;
            rst = 1'b0;
            nstep();
        end
    endtask

    task automatic test_basic();
        logic [31:0] ea [3];
        logic [7:0]  el [3];
        ea = '{32'h1000, 32'h1040, 32'h1080};
        el = '{8'd15, 8'd15, 8'd7};
        clear_log();
        drive_start(32'h1000, 16'd40, 1'b1);
        nstep();
        total++;
        if (busy_o !== 1'b1 || arvalid_o !== 1'b0) begin
            bad++; $display("FAIL basic_t1 got=%b%b want=10", busy_o, arvalid_o);
        end
        nstep();
        total++;
        if (arvalid_o !== 1'b1 || araddr_o !== 32'h1000 || arlen_o !== 8'd15) begin
            bad++; $display("FAIL basic_t2 got=%b/%h/%0d want=1/00001000/15", arvalid_o, araddr_o, arlen_o);
        end
        wait_done(2000);
        total++;
        if (cyc !== last_r_cyc + 2 || busy_o !== 1'b1) begin
            bad++; $display("FAIL basic_done_time got=%0d/%b want=%0d/1", cyc, busy_o, last_r_cyc + 2);
        end
        nstep();
        total++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            bad++; $display("FAIL basic_idle got=%b%b want=00", busy_o, done_o);
        end
        wait_empty(2000);
        total++;
        if (ar_addr_q.size() != 3) begin
            bad++; $display("FAIL basic_ar_count got=%0d want=3", ar_addr_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (ar_addr_q[i] !== ea[i] || ar_len_q[i] !== el[i]) begin
                    bad++; $display("FAIL basic_ar%0d got=%h/%0d want=%h/%0d", i, ar_addr_q[i], ar_len_q[i], ea[i], el[i]);
                end
            end
            for (int i = 1; i < 3; i++) begin
                total++;
                if (ar_cyc_q[i] - ar_cyc_q[i-1] < 2) begin
                    bad++; $display("FAIL basic_ar_gap%0d got=%0d want>=2", i, ar_cyc_q[i] - ar_cyc_q[i-1]);
                end
            end
        end
    endtask

    task automatic test_4k_split();
        clear_log();
        drive_start(32'h0000_0FF0, 16'd16, 1'b1);
        wait_done(2000);
        wait_empty(2000);
        total++;
        if (ar_addr_q.size() != 2) begin
            bad++; $display("FAIL split_count got=%0d want=2", ar_addr_q.size());
        end else begin
            total++;
            if (ar_addr_q[0] !== 32'h0FF0 || ar_len_q[0] !== 8'd3 || ar_addr_q[1] !== 32'h1000 || ar_len_q[1] !== 8'd11) begin
                bad++; $display("FAIL split_ar got=%h/%0d,%h/%0d want=00000ff0/3,00001000/11",
                                ar_addr_q[0], ar_len_q[0], ar_addr_q[1], ar_len_q[1]);
            end
        end
    endtask

    task automatic test_backpressure();
        int o0;
        clear_log();
        ready_hold = 1'b1;
        beats_seen = 0;
        o0 = out_cnt;
        drive_start(32'h2000, 16'd128, 1'b1);
        repeat (400) nstep();
        total++;
        if (beats_seen != 64 || arvalid_o !== 1'b0 || valid_o !== 1'b1 || busy_o !== 1'b1) begin
            bad++; $display("FAIL bp_stall got=%0d/%b want=64/0", beats_seen, arvalid_o);
        end
        ready_hold = 1'b0;
        wait_done(4000);
        wait_empty(4000);
        total++;
        if (out_cnt - o0 != 128 || beats_seen != 128) begin
            bad++; $display("FAIL bp_total got=%0d want=128", out_cnt - o0);
        end
    endtask

    task automatic test_zero_words();
        clear_log();
        drive_start(32'h0100, 16'd0, 1'b0);
        nstep();
        total++;
        if (busy_o !== 1'b1 || done_o !== 1'b0) begin
            bad++; $display("FAIL zero_t1 got=%b%b want=10", busy_o, done_o);
        end
        nstep();
        total++;
        if (done_o !== 1'b1) begin
            bad++; $display("FAIL zero_done got=%b want=1", done_o);
        end
        nstep();
        total++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || ar_addr_q.size() != 0) begin
            bad++; $display("FAIL zero_after got=%b%b/%0d want=00/0", done_o, busy_o, ar_addr_q.size());
        end
    endtask

    task automatic test_start_busy();
        int d0;
        clear_log();
        d0 = done_cnt;
        drive_start(32'h6000, 16'd20, 1'b1);
        nstep(); nstep();
        drive_start(32'h7000, 16'd5, 1'b0);
        wait_done(2000);
        wait_empty(2000);
        repeat (10) nstep();
        total++;
        if (done_cnt - d0 != 1 || ar_addr_q.size() != 2) begin
            bad++; $display("FAIL busy_start got=%0d/%0d want=1/2", done_cnt - d0, ar_addr_q.size());
        end else begin
            total++;
            if (ar_addr_q[0] !== 32'h6000 || ar_addr_q[1] !== 32'h6040) begin
                bad++; $display("FAIL busy_start_ar got=%h,%h want=00006000,00006040", ar_addr_q[0], ar_addr_q[1]);
            end
        end
    endtask

    task automatic test_error();
        beats_seen = 0;
        err_hs_cyc = -1;
        err_beat = 5;
        drive_start(32'h8000, 16'd12, 1'b1);
        for (int i = 0; i < 500 && err_hs_cyc < 0; i++) nstep();
        total++;
        if (err_hs_cyc < 0 || err_o !== 1'b0) begin
            bad++; $display("FAIL err_before got=%b want=0", err_o);
        end
        nstep();
        total++;
        if (err_o !== 1'b1) begin
            bad++; $display("FAIL err_set got=%b want=1", err_o);
        end
        wait_done(2000);
        nstep();
        total++;
        if (err_o !== 1'b1) begin
            bad++; $display("FAIL err_held got=%b want=1", err_o);
        end
        wait_empty(2000);
        err_beat = -1;
        drive_start(32'h9000, 16'd4, 1'b1);
        nstep();
        total++;
        if (err_o !== 1'b0) begin
            bad++; $display("FAIL err_clear got=%b want=0", err_o);
        end
        wait_done(2000);
        wait_empty(2000);
    endtask

    task automatic test_reset_mid();
        int d0;
        clear_log();
        ready_hold = 1'b1;
        ar_budget = 1;
        beats_seen = 0;
        drive_start(32'h3FD8, 16'd100, 1'b1);
        for (int i = 0; i < 300 && !(beats_seen == 10 && arvalid_o); i++) nstep();
        total++;
        if (beats_seen != 10 || arvalid_o !== 1'b1 || valid_o !== 1'b1 || araddr_o !== 32'h4000 || arlen_o !== 8'd15) begin
            bad++; $display("FAIL rmid_pre got=%0d/%b/%b/%h want=10/1/1/00004000", beats_seen, arvalid_o, valid_o, araddr_o);
        end
        d0 = done_cnt;
        @(posedge clk); #2;
        rst = 1'b1;
        nstep();
        total++;
        if (arvalid_o !== 1'b0 || valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 ||
            rready_o !== 1'b0 || data_o !== 32'h0 || araddr_o !== 32'h0 || arlen_o !== 8'h0) begin
            bad++; $display("FAIL rmid_reset got=%b%b%b%b%b want=00000", arvalid_o, valid_o, busy_o, done_o, rready_o);
        end
        exp_q.delete();
        nstep();
        @(posedge clk); #1;
        rst = 1'b0;
        ar_budget = -1;
        ready_hold = 1'b0;
        repeat (6) nstep();
        total++;
        if (done_cnt != d0 || valid_o !== 1'b0) begin
            bad++; $display("FAIL rmid_nodone got=%0d want=%0d", done_cnt, d0);
        end
        clear_log();
        drive_start(32'h5000, 16'd8, 1'b1);
        wait_done(2000);
        wait_empty(2000);
        total++;
        if (ar_addr_q.size() != 1 || ar_addr_q[0] !== 32'h5000 || ar_len_q[0] !== 8'd7) begin
            bad++; $display("FAIL rmid_restart got=%0d ARs want=1 at 00005000 len 7", ar_addr_q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        start_i = 1'b0; base_addr_i = '0; words_i = '0;
        arready_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0; rlast_i = 1'b0;
        rid_i = 4'd0; rresp_i = 2'b00; ready_i = 1'b0;
        test_reset();
        test_basic();
        test_4k_split();
        test_backpressure();
        test_zero_words();
        test_start_busy();
        test_error();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
